// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signals of the shared single-port memory.
// The arbiter uses the slave view. The requesters and memory use the master view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush_if;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_fetch;
  logic        stall_mem;

  modport slave (
    input  if_req, if_addr, flush_if, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_valid, if_rdata, dm_valid, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           stall_fetch, stall_mem
  );

  modport master (
    output if_req, if_addr, flush_if, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_valid, if_rdata, dm_valid, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           stall_fetch, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data memory (DM) requesters.
// DM has strict priority. Each access runs through a fixed-latency FSM.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic {OWN_DM, OWN_IF} owner_e;

  localparam logic [3:0]       LAT_M1  = 4'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             if_valid_q, if_valid_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic             dm_valid_q, dm_valid_d;
  logic [31:0]      dm_rdata_q, dm_rdata_d;
  logic [CNT_W-1:0] conflict_q, conflict_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_valid_d  = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    conflict_d  = conflict_q;

    // A fetch already sent to memory cannot be cancelled, so a redirect only hides its result.
    if (owner_q == OWN_IF && state_q != S_IDLE && bus.flush_if) begin
      drop_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.dm_req) begin
          owner_d     = OWN_DM;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          state_d     = S_ISSUE;
          if (bus.if_req && conflict_q != CNT_MAX) begin
            conflict_d = conflict_q + CNT_W'(1);
          end
        end else if (bus.if_req && !bus.flush_if) begin
          owner_d    = OWN_IF;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The last WAIT cycle is the one in which the memory presents read data.
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          if (owner_q == OWN_IF) begin
            if (!drop_q && !bus.flush_if) begin
              if_valid_d = 1'b1;
              if_rdata_d = bus.mem_rdata;
            end
          end else begin
            dm_valid_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = bus.mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_DM;
      cnt_q       <= 4'd0;
      drop_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      dm_valid_q  <= 1'b0;
      dm_rdata_q  <= 32'd0;
      conflict_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      dm_valid_q  <= dm_valid_d;
      dm_rdata_q  <= dm_rdata_d;
      conflict_q  <= conflict_d;
    end
  end

  assign bus.if_valid    = if_valid_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_valid    = dm_valid_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.stall_mem   = bus.dm_req & ~dm_valid_q;
  assign bus.stall_fetch = (bus.if_req & ~if_valid_q) | (bus.dm_req & ~dm_valid_q);
  assign conflict_cnt    = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter.
// Stimulus queues the expected responses, memory accesses and probes; one monitor process checks them all.
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;
  localparam int CNT_W   = 4;

  localparam int SEL_STALL_F  = 0;
  localparam int SEL_STALL_M  = 1;
  localparam int SEL_CONFLICT = 2;
  localparam int SEL_DM_RDATA = 3;
  localparam int SEL_IF_RDATA = 4;
  localparam int SEL_MEM_EN   = 5;
  localparam int SEL_MEM_WE   = 6;
  localparam int SEL_MEM_ADDR = 7;
  localparam int SEL_MEM_WDAT = 8;
  localparam int SEL_IF_VALID = 9;
  localparam int SEL_DM_VALID = 10;

  typedef struct { bit is_dm; logic [31:0] data; int cyc; } resp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; int cyc; } acc_t;
  typedef struct { string name; int sel; int cyc; logic [31:0] exp; } probe_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [CNT_W-1:0] conflict_cnt;
  int               cyc = 0;
  int               compared = 0;
  int               mismatched = 0;
  int               timeouts = 0;
  bit               all_done = 1'b0;
  int               g;

  resp_t       resp_q[$];
  acc_t        acc_q[$];
  probe_t      probe_q[$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] rd_pipe [MEM_LAT+1] = '{default: 32'hBADC0DE0};

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] read_model(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    case (a)
      32'h0000_0040: return 32'hE3A0_1005;
      32'h0000_0080: return 32'h3333_4444;
      32'h0000_0100: return 32'h1111_2222;
      default:       return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // Memory model: read data appears in the cycle MEM_LAT after mem_en, junk otherwise.
  always @(negedge clk) begin
    for (int i = MEM_LAT; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    if (bus.mem_en) begin
      if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
      rd_pipe[0] = read_model(bus.mem_addr);
    end else begin
      rd_pipe[0] = 32'hBADC0DE0;
    end
    bus.mem_rdata = rd_pipe[MEM_LAT];
  end

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      SEL_STALL_F:  return {31'd0, bus.stall_fetch};
      SEL_STALL_M:  return {31'd0, bus.stall_mem};
      SEL_CONFLICT: return {{(32-CNT_W){1'b0}}, conflict_cnt};
      SEL_DM_RDATA: return bus.dm_rdata;
      SEL_IF_RDATA: return bus.if_rdata;
      SEL_MEM_EN:   return {31'd0, bus.mem_en};
      SEL_MEM_WE:   return {31'd0, bus.mem_we};
      SEL_MEM_ADDR: return bus.mem_addr;
      SEL_MEM_WDAT: return bus.mem_wdata;
      SEL_IF_VALID: return {31'd0, bus.if_valid};
      SEL_DM_VALID: return {31'd0, bus.dm_valid};
      default:      return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the only process that compares, sampling on the falling edge.
  always @(negedge clk) begin
    resp_t  r;
    acc_t   a;
    probe_t p;
    if (bus.if_valid || bus.dm_valid) begin
      if (resp_q.size() == 0) begin
        checkOutput("unexpected_valid", {30'd0, bus.if_valid, bus.dm_valid}, 32'd0);
      end else begin
        r = resp_q.pop_front();
        checkOutput("resp_is_dm", {31'd0, bus.dm_valid}, {31'd0, r.is_dm});
        checkOutput("resp_cycle", cyc, r.cyc);
        checkOutput(r.is_dm ? "dm_rdata" : "if_rdata", r.is_dm ? bus.dm_rdata : bus.if_rdata, r.data);
      end
    end
    if (bus.mem_en) begin
      if (acc_q.size() == 0) begin
        checkOutput("unexpected_mem_en", 32'd1, 32'd0);
      end else begin
        a = acc_q.pop_front();
        checkOutput("mem_en_cycle", cyc, a.cyc);
        checkOutput("mem_we", {31'd0, bus.mem_we}, {31'd0, a.we});
        checkOutput("mem_addr", bus.mem_addr, a.addr);
        if (a.we) checkOutput("mem_wdata", bus.mem_wdata, a.wdata);
      end
    end
    for (int i = probe_q.size() - 1; i >= 0; i--) begin
      p = probe_q[i];
      if (p.cyc == cyc) begin
        checkOutput(p.name, sample(p.sel), p.exp);
        probe_q.delete(i);
      end else if (p.cyc < cyc) begin
        checkOutput({"stale_", p.name}, 32'd1, 32'd0);
        probe_q.delete(i);
      end
    end
    if (all_done || cyc > 3000) begin
      if (!all_done) checkOutput("watchdog", 32'd0, 32'd1);
      checkOutput("timeouts", timeouts, 32'd0);
      checkOutput("resp_left", resp_q.size(), 32'd0);
      checkOutput("acc_left", acc_q.size(), 32'd0);
      checkOutput("probe_left", probe_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input bit is_dm, input logic [31:0] data, input int c);
    resp_q.push_back('{is_dm: is_dm, data: data, cyc: c});
  endtask

  task automatic expect_acc(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input int c);
    acc_q.push_back('{we: we, addr: addr, wdata: wdata, cyc: c});
  endtask

  task automatic expect_probe(input string name, input int sel, input int c, input logic [31:0] exp);
    probe_q.push_back('{name: name, sel: sel, cyc: c, exp: exp});
  endtask

  task automatic applyStimulus(input bit is_dm, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    if (is_dm) begin
      bus.dm_req   = 1'b1;
      bus.dm_we    = we;
      bus.dm_addr  = addr;
      bus.dm_wdata = wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
  endtask

  task automatic wait_valid(input bit is_dm);
    int n = 0;
    while (!(is_dm ? bus.dm_valid : bus.if_valid) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeouts++;
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.flush_if = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'd0; bus.dm_wdata = 32'd0;
    reset = 1'b0;
    repeat (3) tick();
    expect_probe("rst_mem_en",   SEL_MEM_EN,   cyc, 32'd0);
    expect_probe("rst_mem_we",   SEL_MEM_WE,   cyc, 32'd0);
    expect_probe("rst_mem_addr", SEL_MEM_ADDR, cyc, 32'd0);
    expect_probe("rst_if_rdata", SEL_IF_RDATA, cyc, 32'd0);
    expect_probe("rst_dm_rdata", SEL_DM_RDATA, cyc, 32'd0);
    expect_probe("rst_conflict", SEL_CONFLICT, cyc, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Plain fetch of 0x40.
    g = cyc;
    applyStimulus(1'b0, 1'b0, 32'h40, 32'd0);
    expect_acc(1'b0, 32'h40, 32'd0, g + 1);
    expect_resp(1'b0, 32'hE3A0_1005, g + 4);
    for (int k = 0; k < 4; k++) expect_probe("t1_stall_fetch", SEL_STALL_F, g + k, 32'd1);
    expect_probe("t1_stall_fetch_rel", SEL_STALL_F, g + 4, 32'd0);
    wait_valid(1'b0);
    tick();
    bus.if_req = 1'b0;
    tick();

    // Fetch of 0x44 and load of 0x100 arrive together; DM goes first.
    g = cyc;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h44, 32'd0);
    expect_acc(1'b0, 32'h100, 32'd0, g + 1);
    expect_resp(1'b1, 32'h1111_2222, g + 4);
    expect_acc(1'b0, 32'h44, 32'd0, g + 6);
    expect_resp(1'b0, 32'hA5A5_A5E1, g + 9);
    expect_probe("t2_conflict_pre", SEL_CONFLICT, g, 32'd0);
    expect_probe("t2_conflict", SEL_CONFLICT, g + 1, 32'd1);
    expect_probe("t2_stall_mem", SEL_STALL_M, g + 3, 32'd1);
    expect_probe("t2_stall_mem_rel", SEL_STALL_M, g + 4, 32'd0);
    expect_probe("t2_stall_fetch", SEL_STALL_F, g + 4, 32'd1);
    expect_probe("t2_conflict_hold", SEL_CONFLICT, g + 9, 32'd1);
    wait_valid(1'b1);
    tick();
    bus.dm_req = 1'b0;
    wait_valid(1'b0);
    tick();
    bus.if_req = 1'b0;
    tick();

    // Store 0xDEADBEEF to 0x200, then a back-to-back load of the same word.
    g = cyc;
    applyStimulus(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
    expect_acc(1'b1, 32'h200, 32'hDEAD_BEEF, g + 1);
    expect_resp(1'b1, 32'h1111_2222, g + 4);
    expect_probe("t3_mem_we_hold", SEL_MEM_WE, g + 4, 32'd1);
    expect_acc(1'b0, 32'h200, 32'd0, g + 6);
    expect_resp(1'b1, 32'hDEAD_BEEF, g + 9);
    wait_valid(1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h200, 32'd0);
    wait_valid(1'b1);
    tick();
    bus.dm_req = 1'b0;
    tick();

    // Redirect during WAIT of a fetch of 0x48; the new fetch of 0x80 follows.
    g = cyc;
    applyStimulus(1'b0, 1'b0, 32'h48, 32'd0);
    expect_acc(1'b0, 32'h48, 32'd0, g + 1);
    expect_probe("t4_no_if_valid", SEL_IF_VALID, g + 4, 32'd0);
    expect_probe("t4_if_rdata_kept", SEL_IF_RDATA, g + 4, 32'hA5A5_A5E1);
    expect_probe("t4_stall_fetch", SEL_STALL_F, g + 4, 32'd1);
    expect_acc(1'b0, 32'h80, 32'd0, g + 6);
    expect_resp(1'b0, 32'h3333_4444, g + 9);
    tick();
    tick();
    bus.flush_if = 1'b1;
    bus.if_addr  = 32'h80;
    tick();
    bus.flush_if = 1'b0;
    wait_valid(1'b0);
    tick();
    bus.if_req = 1'b0;
    tick();

    // Reset asserted mid-cycle during WAIT of a load.
    g = cyc;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h5555_AAAA);
    expect_acc(1'b0, 32'h100, 32'd0, g + 1);
    expect_probe("t5_stall_mem", SEL_STALL_M, g + 1, 32'd1);
    tick();
    tick();
    expect_probe("t5_mem_addr", SEL_MEM_ADDR, g + 2, 32'd0);
    expect_probe("t5_mem_wdata", SEL_MEM_WDAT, g + 2, 32'd0);
    expect_probe("t5_if_rdata", SEL_IF_RDATA, g + 2, 32'd0);
    expect_probe("t5_dm_rdata", SEL_DM_RDATA, g + 2, 32'd0);
    expect_probe("t5_conflict", SEL_CONFLICT, g + 2, 32'd0);
    #1;
    reset = 1'b0;
    bus.dm_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) expect_probe("t5_no_dm_valid", SEL_DM_VALID, cyc + k, 32'd0);
    repeat (8) tick();

    // Twenty back-to-back conflicting grants saturate the 4-bit counter.
    g = cyc;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h40, 32'd0);
    for (int k = 0; k < 20; k++) begin
      expect_acc(1'b0, 32'h100, 32'd0, g + 1 + 5 * k);
      expect_resp(1'b1, 32'h1111_2222, g + 4 + 5 * k);
    end
    expect_probe("t6_conflict_1", SEL_CONFLICT, g + 1, 32'd1);
    expect_probe("t6_conflict_14", SEL_CONFLICT, g + 66, 32'd14);
    expect_probe("t6_conflict_15", SEL_CONFLICT, g + 71, 32'd15);
    expect_probe("t6_conflict_sat", SEL_CONFLICT, g + 96, 32'd15);
    expect_probe("t6_stall_fetch", SEL_STALL_F, g + 4, 32'd1);
    expect_probe("t6_stall_mem_rel", SEL_STALL_M, g + 4, 32'd0);
    expect_probe("t6_stall_mem_again", SEL_STALL_M, g + 5, 32'd1);
    repeat (100) tick();
    bus.dm_req = 1'b0;
    expect_acc(1'b0, 32'h40, 32'd0, g + 101);
    expect_resp(1'b0, 32'hE3A0_1005, g + 104);
    expect_probe("t6_conflict_end", SEL_CONFLICT, g + 104, 32'd15);
    wait_valid(1'b0);
    tick();
    bus.if_req = 1'b0;
    repeat (5) tick();
    all_done = 1'b1;
  end

endmodule
